// File: rtl/uop_sequencer.sv
// Microcode sequencer: walks a registered microcode ROM from address 0 and
// dispatches decoded micro-ops to an arithmetic engine, one at a time.
module uop_sequencer #(
    parameter int UOP_ADDR_W = 6,
    parameter int UOP_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    output logic                  rdy,
    output logic [UOP_ADDR_W-1:0] uop_addr,
    input  logic [UOP_W-1:0]      uop_data,
    input  logic                  cond,
    output logic                  exec_ena,
    output logic [3:0]            exec_opcode,
    output logic [4:0]            exec_src_a,
    output logic [4:0]            exec_src_b,
    output logic [4:0]            exec_dst,
    input  logic                  exec_rdy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_EXEC   = 2'd3;

    localparam logic [3:0]            OP_RDY   = 4'h0;
    localparam logic [UOP_ADDR_W-1:0] ADDR_ONE = {{(UOP_ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [3:0] opcode;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic [4:0] dst;
    logic       always_flag;
    logic       last_addr;

    assign opcode      = uop_data[19:16];
    assign src_a       = uop_data[15:11];
    assign src_b       = uop_data[10:6];
    assign dst         = uop_data[5:1];
    assign always_flag = uop_data[0];
    // The top ROM word ends the program instead of wrapping back to 0.
    assign last_addr   = &uop_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rdy         <= 1'b1;
            exec_ena    <= 1'b0;
            uop_addr    <= '0;
            exec_opcode <= '0;
            exec_src_a  <= '0;
            exec_src_b  <= '0;
            exec_dst    <= '0;
        end else begin
            exec_ena <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        uop_addr <= '0;
                        rdy      <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (opcode == OP_RDY) begin
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end else if (!always_flag && !cond) begin
                        if (last_addr) begin
                            rdy   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            uop_addr <= uop_addr + ADDR_ONE;
                            state    <= S_FETCH;
                        end
                    end else begin
                        exec_opcode <= opcode;
                        exec_src_a  <= src_a;
                        exec_src_b  <= src_b;
                        exec_dst    <= dst;
                        exec_ena    <= 1'b1;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A completion seen alongside the dispatch strobe belongs to nothing.
                    if (exec_rdy && !exec_ena) begin
                        if (last_addr) begin
                            rdy   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            uop_addr <= uop_addr + ADDR_ONE;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uop_sequencer.sv
// Randomized bench for uop_sequencer: ROM, condition table and engine models
// drive the DUT; a program-level reference model predicts dispatches and timing.
module tb_uop_sequencer;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        rdy;
    logic [5:0]  uop_addr;
    logic [19:0] uop_data;
    logic        cond;
    logic        exec_ena;
    logic [3:0]  exec_opcode;
    logic [4:0]  exec_src_a;
    logic [4:0]  exec_src_b;
    logic [4:0]  exec_dst;
    logic        exec_rdy;

    uop_sequencer #(.UOP_ADDR_W(6), .UOP_W(20)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rdy(rdy), .uop_addr(uop_addr),
        .uop_data(uop_data), .cond(cond), .exec_ena(exec_ena),
        .exec_opcode(exec_opcode), .exec_src_a(exec_src_a), .exec_src_b(exec_src_b),
        .exec_dst(exec_dst), .exec_rdy(exec_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [19:0] rom [64];
    bit          condtab [64];

    // registered ROM: data follows the address by one clock
    always @(posedge clk) uop_data <= rom[uop_addr];
    assign cond = condtab[uop_addr];

    // engine model: completion eng_lat cycles after each dispatch
    int          eng_lat = 1;
    bit          eng_noise = 0;
    int          eng_cnt = 0;
    int          stab_err = 0;
    logic [24:0] cur;
    logic [24:0] cap_q [$];

    always @(negedge clk) begin
        if (rst) begin
            eng_cnt  = 0;
            exec_rdy = 1'b0;
        end else begin
            if (eng_cnt > 0 && (exec_ena ||
                {uop_addr, exec_opcode, exec_src_a, exec_src_b, exec_dst} !== cur))
                stab_err++;
            exec_rdy = 1'b0;
            if (exec_ena) begin
                cur = {uop_addr, exec_opcode, exec_src_a, exec_src_b, exec_dst};
                cap_q.push_back(cur);
                eng_cnt  = eng_lat;
                exec_rdy = eng_noise;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) exec_rdy = 1'b1;
            end else if (eng_noise) begin
                exec_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    // reference model: walk the program by the sequencing rules
    logic [24:0] exp_q [$];
    int          exp_cyc;
    int          exp_fin;

    task automatic model_run(input int lat);
        int a;
        logic [19:0] w;
        exp_q.delete();
        exp_cyc = 0;
        a = 0;
        while (1) begin
            w = rom[a];
            exp_cyc += 2;
            if (w[19:16] == 4'h0) break;
            if (w[0] || condtab[a]) begin
                exp_q.push_back({6'(a), w[19:1]});
                exp_cyc += lat + 1;
            end
            if (a == 63) break;
            a++;
        end
        exp_fin = a;
    endtask

    function automatic logic [19:0] mkw(input logic [3:0] op, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] d,
                                        input logic f);
        return {op, a, b, d, f};
    endfunction

    task automatic gen_rom(input int rdy_pct);
        logic [19:0] w;
        for (int i = 0; i < 64; i++) begin
            w = 20'($urandom());
            if ($urandom_range(0, 99) < rdy_pct) w[19:16] = 4'h0;
            else if (w[19:16] == 4'h0) w[19:16] = 4'h1;
            rom[i] = w;
            condtab[i] = 1'($urandom_range(0, 1));
        end
    endtask

    int   addr_tr [$];

    task automatic run_prog(input int lat, input bit noise,
                            output int cyc, output int first, output bit to);
        eng_lat   = lat;
        eng_noise = noise;
        cap_q.delete();
        addr_tr.delete();
        cyc = 0;
        first = 0;
        to = 0;
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        while (rdy !== 1'b1) begin
            cyc++;
            addr_tr.push_back(int'(uop_addr));
            if (exec_ena && first == 0) first = cyc;
            if (noise) ena = 1'($urandom_range(0, 1));
            if (cyc > 4000) begin
                to = 1;
                break;
            end
            @(negedge clk);
        end
        ena = 1'b0;
        eng_noise = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
        n_chk++; if (exec_ena !== 1'b0) $display("FAIL reset_exec_ena: got %b want 0", exec_ena); else n_pass++;
        n_chk++; if (uop_addr !== 6'd0) $display("FAIL reset_addr: got %0d want 0", uop_addr); else n_pass++;
        n_chk++;
        if ({exec_opcode, exec_src_a, exec_src_b, exec_dst} !== 19'h0)
            $display("FAIL reset_fields: got %0h want 0", {exec_opcode, exec_src_a, exec_src_b, exec_dst});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, first;
        bit to;
        logic [4:0] dsts [3];
        int exp_tr [$];
        dsts[0] = 5'd2; dsts[1] = 5'd3; dsts[2] = 5'd4;
        gen_rom(0);
        rom[0] = mkw(4'h1, 5'd1, 5'd0, dsts[0], 1'b1);
        rom[1] = mkw(4'h1, 5'd1, 5'd0, dsts[1], 1'b1);
        rom[2] = mkw(4'h1, 5'd0, 5'd0, dsts[2], 1'b1);
        rom[3] = 20'h0;
        model_run(1);
        run_prog(1, 0, cyc, first, to);
        n_chk++; if (to) $display("FAIL basic_timeout: got busy want rdy"); else n_pass++;
        n_chk++; if (cyc != exp_cyc) $display("FAIL basic_cycles: got %0d want %0d", cyc, exp_cyc); else n_pass++;
        n_chk++; if (first != 3) $display("FAIL basic_first_exec: got edge %0d want 3", first); else n_pass++;
        n_chk++; if (cap_q.size() != 3) $display("FAIL basic_ndisp: got %0d want 3", cap_q.size()); else n_pass++;
        for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i][4:0] !== dsts[i]) $display("FAIL basic_dst%0d: got %0d want %0d", i, cap_q[i][4:0], dsts[i]);
            else n_pass++;
            n_chk++;
            if (cap_q[i] !== exp_q[i]) $display("FAIL basic_disp%0d: got %0h want %0h", i, cap_q[i], exp_q[i]);
            else n_pass++;
        end
        for (int a = 0; a < 3; a++) repeat (4) exp_tr.push_back(a);
        exp_tr.push_back(3); exp_tr.push_back(3);
        n_chk++; if (addr_tr.size() != exp_tr.size()) $display("FAIL basic_trace_len: got %0d want %0d", addr_tr.size(), exp_tr.size()); else n_pass++;
        for (int i = 0; i < exp_tr.size() && i < addr_tr.size(); i++) begin
            n_chk++;
            if (addr_tr[i] != exp_tr[i]) $display("FAIL basic_trace%0d: got %0d want %0d", i, addr_tr[i], exp_tr[i]);
            else n_pass++;
        end
        n_chk++; if (uop_addr !== 6'd3) $display("FAIL basic_final_addr: got %0d want 3", uop_addr); else n_pass++;
    endtask

    task automatic test_skip;
        int cyc, first;
        bit to;
        for (int c = 0; c < 2; c++) begin
            gen_rom(0);
            for (int i = 0; i < 4; i++) rom[i][0] = 1'b1;
            rom[1][0] = 1'b0;
            rom[4] = 20'h0;
            condtab[1] = (c == 1);
            model_run(2);
            run_prog(2, 0, cyc, first, to);
            n_chk++; if (to) $display("FAIL skip%0d_timeout: got busy want rdy", c); else n_pass++;
            n_chk++; if (cyc != exp_cyc) $display("FAIL skip%0d_cycles: got %0d want %0d", c, cyc, exp_cyc); else n_pass++;
            n_chk++; if (cap_q.size() != 3 + c) $display("FAIL skip%0d_ndisp: got %0d want %0d", c, cap_q.size(), 3 + c); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                n_chk++;
                if (cap_q[i] !== exp_q[i]) $display("FAIL skip%0d_disp%0d: got %0h want %0h", c, i, cap_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall;
        int cyc, first, err0;
        bit to;
        gen_rom(0);
        for (int i = 0; i < 3; i++) rom[i][0] = 1'b1;
        rom[3] = 20'h0;
        err0 = stab_err;
        model_run(11);
        run_prog(11, 0, cyc, first, to);
        n_chk++; if (to) $display("FAIL stall_timeout: got busy want rdy"); else n_pass++;
        n_chk++; if (stab_err != err0) $display("FAIL stall_stable: got %0d violations want 0", stab_err - err0); else n_pass++;
        n_chk++; if (cyc != exp_cyc) $display("FAIL stall_cycles: got %0d want %0d", cyc, exp_cyc); else n_pass++;
        n_chk++; if (cap_q.size() != 3) $display("FAIL stall_ndisp: got %0d want 3", cap_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) $display("FAIL stall_disp%0d: got %0h want %0h", i, cap_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_no_rdy;
        int cyc, first;
        bit to;
        gen_rom(0);
        for (int i = 0; i < 64; i++) rom[i][0] = 1'b1;
        model_run(1);
        run_prog(1, 0, cyc, first, to);
        n_chk++; if (to) $display("FAIL nordy_timeout: got busy want rdy"); else n_pass++;
        n_chk++; if (cap_q.size() != 64) $display("FAIL nordy_ndisp: got %0d want 64", cap_q.size()); else n_pass++;
        n_chk++; if (cyc != exp_cyc) $display("FAIL nordy_cycles: got %0d want %0d", cyc, exp_cyc); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) $display("FAIL nordy_disp%0d: got %0h want %0h", i, cap_q[i], exp_q[i]);
            else n_pass++;
        end
        repeat (5) @(negedge clk);
        n_chk++; if (uop_addr !== 6'd63) $display("FAIL nordy_addr: got %0d want 63", uop_addr); else n_pass++;
        n_chk++; if (rdy !== 1'b1) $display("FAIL nordy_rdy: got %b want 1", rdy); else n_pass++;
        n_chk++; if (cap_q.size() != 64) $display("FAIL nordy_extra: got %0d dispatches want 64", cap_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc, first, n, w;
        bit to;
        gen_rom(0);
        for (int i = 0; i < 64; i++) rom[i][0] = 1'b1;
        eng_lat = 30;
        cap_q.delete();
        @(negedge clk) ena = 1'b1;
        @(negedge clk) ena = 1'b0;
        w = 0;
        while (cap_q.size() < 3 && w < 500) begin
            w++;
            @(negedge clk);
        end
        n_chk++; if (w >= 500) $display("FAIL rstmid_wait: got %0d dispatches want 3", cap_q.size()); else n_pass++;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++; if (rdy !== 1'b1) $display("FAIL rstmid_rdy: got %b want 1", rdy); else n_pass++;
        n_chk++; if (exec_ena !== 1'b0) $display("FAIL rstmid_exec_ena: got %b want 0", exec_ena); else n_pass++;
        n_chk++; if (uop_addr !== 6'd0) $display("FAIL rstmid_addr: got %0d want 0", uop_addr); else n_pass++;
        n_chk++;
        if ({exec_opcode, exec_src_a, exec_src_b, exec_dst} !== 19'h0)
            $display("FAIL rstmid_fields: got %0h want 0", {exec_opcode, exec_src_a, exec_src_b, exec_dst});
        else n_pass++;
        n = cap_q.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++; if (cap_q.size() != n) $display("FAIL rstmid_abort: got %0d dispatches want %0d", cap_q.size(), n); else n_pass++;
        n_chk++; if (rdy !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", rdy); else n_pass++;
        gen_rom(5);
        model_run(2);
        run_prog(2, 0, cyc, first, to);
        n_chk++; if (to) $display("FAIL rstmid_rerun_timeout: got busy want rdy"); else n_pass++;
        n_chk++; if (cyc != exp_cyc) $display("FAIL rstmid_rerun_cycles: got %0d want %0d", cyc, exp_cyc); else n_pass++;
        n_chk++; if (cap_q.size() != exp_q.size()) $display("FAIL rstmid_rerun_ndisp: got %0d want %0d", cap_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) $display("FAIL rstmid_rerun_disp%0d: got %0h want %0h", i, cap_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random(input bit noise, input int iters);
        int cyc, first, lat, err0;
        bit to;
        for (int it = 0; it < iters; it++) begin
            gen_rom(6);
            lat = $urandom_range(1, 4);
            err0 = stab_err;
            model_run(lat);
            run_prog(lat, noise, cyc, first, to);
            n_chk++; if (to) $display("FAIL rand%0d_%0d_timeout: got busy want rdy", noise, it); else n_pass++;
            n_chk++; if (cyc != exp_cyc) $display("FAIL rand%0d_%0d_cycles: got %0d want %0d", noise, it, cyc, exp_cyc); else n_pass++;
            n_chk++; if (uop_addr !== 6'(exp_fin)) $display("FAIL rand%0d_%0d_final: got %0d want %0d", noise, it, uop_addr, exp_fin); else n_pass++;
            n_chk++; if (stab_err != err0) $display("FAIL rand%0d_%0d_stable: got %0d violations want 0", noise, it, stab_err - err0); else n_pass++;
            n_chk++; if (cap_q.size() != exp_q.size()) $display("FAIL rand%0d_%0d_ndisp: got %0d want %0d", noise, it, cap_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
                n_chk++;
                if (cap_q[i] !== exp_q[i]) $display("FAIL rand%0d_%0d_disp%0d: got %0h want %0h", noise, it, i, cap_q[i], exp_q[i]);
                else n_pass++;
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        exec_rdy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 20'h0;
            condtab[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_skip();
        test_stall();
        test_no_rdy();
        test_reset_mid();
        test_random(0, 6);
        test_random(1, 4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
